// File: rtl/mod_n_pkg.sv
// Shared defaults for the mod-N counter and its event-capture consumer.
package mod_n_pkg;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_N       = 10;
    localparam int DEF_EPOCH_W = 8;
    localparam int DEF_DEPTH   = 4;

    // Occupancy needs one extra bit so a full FIFO can report DEPTH itself.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/mod_n_capture_cap_fifo.sv
// Synchronous FIFO, power-of-2 depth, full/empty from pointers carrying one extra wrap bit.
module cap_fifo
    import mod_n_pkg::*;
#(
    parameter int DW    = 12,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [DW-1:0]           wdata,
    output logic [DW-1:0]           rdata,
    output logic                    full,
    output logic                    empty,
    output logic [lvl_w(DEPTH)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic [AW:0]   level_q, level_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        mem_d   = mem_q;
        if (push) begin
            mem_d[wptr_q[AW-1:0]] = wdata;
            wptr_d = wptr_q + PTR_ONE;
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + PTR_ONE;
            2'b01:   level_d = level_q - PTR_ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage is never reset; stale words are unreachable once the pointers are cleared.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata = mem_q[rptr_q[AW-1:0]];
    assign level = level_q;

endmodule

// File: rtl/mod_n_capture.sv
// Timestamps rising edges of evt with {wrap epoch, counter value} and queues them for readout.
module mod_n_capture
    import mod_n_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int N       = DEF_N,
    parameter int EPOCH_W = DEF_EPOCH_W,
    parameter int DEPTH   = DEF_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cnt_en,
    input  logic [WIDTH-1:0]        count,
    input  logic                    evt,
    input  logic                    clr_ovf,
    output logic                    cap_valid,
    input  logic                    cap_ready,
    output logic [WIDTH-1:0]        cap_count,
    output logic [EPOCH_W-1:0]      cap_epoch,
    output logic [lvl_w(DEPTH)-1:0] cap_level,
    output logic                    ovf
);

    typedef struct packed {
        logic [EPOCH_W-1:0] epoch;
        logic [WIDTH-1:0]   count;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    logic               evt_q, evt_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic               ovf_q, ovf_d;

    logic   rise, wrap, push, pop, drop;
    logic   fifo_full, fifo_empty;
    entry_t wr_entry, head;

    always_comb begin
        rise     = evt & ~evt_q;
        wrap     = cnt_en && (count == WIDTH'(N - 1));
        pop      = ~fifo_empty & cap_ready;
        push     = rise & (~fifo_full | pop);
        drop     = rise & fifo_full & ~pop;
        wr_entry = '{epoch: epoch_q, count: count};

        evt_d   = evt;
        epoch_d = wrap ? epoch_q + EPOCH_W'(1) : epoch_q;
        // A drop in the same cycle as a clear must leave the flag set.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // evt_q comes out of reset high so a level held across reset is not a rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_q   <= 1'b1;
            epoch_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            evt_q   <= evt_d;
            epoch_q <= epoch_d;
            ovf_q   <= ovf_d;
        end
    end

    cap_fifo #(
        .DW    (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (cap_level)
    );

    assign cap_valid = ~fifo_empty;
    assign cap_count = cap_valid ? head.count : '0;
    assign cap_epoch = cap_valid ? head.epoch : '0;
    assign ovf       = ovf_q;

endmodule
